// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller.
//   rx_state_e     : controller FSM states (off / hunting for idle line / running)
//   *_DEF          : default character format, must match the receive core
//   TIMEOUT_MULT   : idle timeout length in character times
package uart_pkg;

  localparam int unsigned DATA_BITS_DEF  = 8;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned TIMEOUT_MULT   = 4;

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StHunt = 2'd1,
    StRun  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive byte stream (valid/ready).
//   m_data  : head byte, held stable while m_valid && !m_ready
//   m_valid : a byte is available
//   m_ready : consumer accepts the head byte this cycle
// master = producer (controller), slave = consumer.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst        : clock, asynchronous active-high reset
//   i_push, i_data  : write request and byte; ignored when full unless i_pop is also set
//   i_pop           : read request; ignored when empty
//   o_data          : head entry (valid while !o_empty)
//   o_full, o_empty : status
//   o_level         : exact entry count, 0..FIFO_DEPTH
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_pop,
  output logic [DATA_BITS-1:0]          o_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [LvlW-1:0]      r_level;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LvlW'(FIFO_DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Pointers are PtrW bits wide, so they wrap modulo the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_do_push && !w_do_pop)      r_level <= r_level + LvlW'(1);
      else if (w_do_pop && !w_do_push) r_level <= r_level - LvlW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Controller around the 16x-oversampling UART receive core.
//   clk, rst            : clock, asynchronous active-high reset
//   i_enable            : receiver enable
//   i_baud_div          : os_tick period minus one, in clk cycles
//   i_rx_pin            : raw asynchronous line
//   o_os_tick           : one-cycle oversample pulse to the core
//   o_rx_sync           : synchronized line to the core
//   o_core_rst          : core reset, released only once the line was seen idle
//   i_core_data/valid   : byte from the core
//   i_core_ferr         : core framing-error level
//   m_if                : received-byte stream (FWFT FIFO head)
//   o_fifo_level        : FIFO occupancy
//   o_overrun           : sticky, a byte was dropped on a full FIFO
//   o_ferr_sticky/count : sticky framing error flag and saturating count
//   i_clr_status        : clears the status; a coincident event wins
//   o_idle_to           : idle-timeout pulse, built only with UART_RX_CTRL_TIMEOUT_EN
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic [DIV_W-1:0]            i_baud_div,
  input  logic                        i_rx_pin,
  output logic                        o_os_tick,
  output logic                        o_rx_sync,
  output logic                        o_core_rst,
  input  logic [DATA_BITS-1:0]        i_core_data,
  input  logic                        i_core_valid,
  input  logic                        i_core_ferr,
  uart_rx_ctrl_if.master              m_if,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic                        o_overrun,
  output logic                        o_ferr_sticky,
  output logic [7:0]                  o_ferr_count,
  input  logic                        i_clr_status,
  output logic                        o_idle_to
);

  localparam int unsigned IdleW = $clog2(OVERSAMPLE) + 1;

  // Oversample tick generator.
  logic [DIV_W-1:0] r_tick_cnt;
  logic             r_os_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_os_tick  <= 1'b0;
    end else if (!i_enable) begin
      r_tick_cnt <= '0;
      r_os_tick  <= 1'b0;
    end else if (r_tick_cnt >= i_baud_div) begin
      // >= so a divisor lowered below the running count ticks immediately.
      r_tick_cnt <= '0;
      r_os_tick  <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + DIV_W'(1);
      r_os_tick  <= 1'b0;
    end
  end

  assign o_os_tick = r_os_tick;

  // Line synchronizer, reset to the idle (mark) level.
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx_pin};
  end

  assign o_rx_sync = r_sync[SYNC_STAGES-1];

  // Controller FSM: wait for OVERSAMPLE consecutive idle-high ticks before running the core.
  rx_state_e        r_state, w_state_d;
  logic [IdleW-1:0] r_idle_cnt, w_idle_cnt_d;
  logic             r_core_rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StOff;
      r_idle_cnt <= '0;
      r_core_rst <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_idle_cnt <= w_idle_cnt_d;
      r_core_rst <= (r_state != StRun);
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_idle_cnt_d = r_idle_cnt;
    case (r_state)
      StOff: begin
        w_idle_cnt_d = '0;
        if (i_enable) w_state_d = StHunt;
      end
      StHunt: begin
        // Disabling while hunting falls back to off rather than waiting forever.
        if (!i_enable) begin
          w_state_d    = StOff;
          w_idle_cnt_d = '0;
        end else if (r_os_tick) begin
          if (!o_rx_sync)                                 w_idle_cnt_d = '0;
          else if (r_idle_cnt == IdleW'(OVERSAMPLE - 1)) w_state_d    = StRun;
          else                                            w_idle_cnt_d = r_idle_cnt + IdleW'(1);
        end
      end
      StRun: begin
        if (!i_enable) w_state_d = StOff;
      end
      default: w_state_d = StOff;
    endcase
  end

  assign o_core_rst = r_core_rst;

  // Receive FIFO. Leaving RUN does not flush it; the consumer keeps draining.
  logic                 w_full, w_empty, w_pop, w_push_req, w_push_ok, w_drop;
  logic [DATA_BITS-1:0] w_fifo_data;

  assign w_pop      = m_if.m_valid && m_if.m_ready;
  assign w_push_req = i_core_valid && (r_state == StRun);
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  uart_rx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_ok),
    .i_data  (i_core_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  assign m_if.m_data  = w_fifo_data;
  assign m_if.m_valid = !w_empty;

  // Sticky status; an event coincident with clear takes precedence.
  logic       r_ferr_prev, r_overrun, r_ferr_sticky;
  logic [7:0] r_ferr_count;
  logic       w_ferr_rise;

  assign w_ferr_rise = i_core_ferr && !r_ferr_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ferr_prev   <= 1'b0;
      r_overrun     <= 1'b0;
      r_ferr_sticky <= 1'b0;
      r_ferr_count  <= '0;
    end else begin
      r_ferr_prev <= i_core_ferr;
      if (w_drop)            r_overrun <= 1'b1;
      else if (i_clr_status) r_overrun <= 1'b0;
      if (w_ferr_rise) begin
        r_ferr_sticky <= 1'b1;
        if (i_clr_status)               r_ferr_count <= 8'd1;
        else if (r_ferr_count != 8'hFF) r_ferr_count <= r_ferr_count + 8'd1;
      end else if (i_clr_status) begin
        r_ferr_sticky <= 1'b0;
        r_ferr_count  <= '0;
      end
    end
  end

  assign o_overrun     = r_overrun;
  assign o_ferr_sticky = r_ferr_sticky;
  assign o_ferr_count  = r_ferr_count;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int unsigned ToLimit = TIMEOUT_MULT * (DATA_BITS + 2) * OVERSAMPLE;
  localparam int unsigned ToW     = $clog2(ToLimit + 1);

  logic [ToW-1:0] r_to_cnt;
  logic           r_idle_to;
  logic           w_to_clr;

  assign w_to_clr = w_push_ok || w_empty;

  // Counter parks at ToLimit so each idle period yields a single pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_idle_to <= 1'b0;
    end else begin
      r_idle_to <= !w_to_clr && r_os_tick && (r_to_cnt == ToW'(ToLimit - 1));
      if (w_to_clr)                                    r_to_cnt <= '0;
      else if (r_os_tick && r_to_cnt != ToW'(ToLimit)) r_to_cnt <= r_to_cnt + ToW'(1);
    end
  end

  assign o_idle_to = r_idle_to;
`else
  assign o_idle_to = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed stimulus, a reference model checked every cycle,
// and literal expectations at key points.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int TO_LIMIT = 640;

  logic        clk, rst, en, rx_pin, core_valid, core_ferr, clr;
  logic [15:0] baud;
  logic [7:0]  core_data;
  logic        os_tick, rx_sync, core_rst, overrun, ferr_sticky, idle_to;
  logic [3:0]  level;
  logic [7:0]  ferr_count;

  uart_rx_ctrl_if #(.DATA_BITS(8)) m_if ();

  uart_rx_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (en),
    .i_baud_div    (baud),
    .i_rx_pin      (rx_pin),
    .o_os_tick     (os_tick),
    .o_rx_sync     (rx_sync),
    .o_core_rst    (core_rst),
    .i_core_data   (core_data),
    .i_core_valid  (core_valid),
    .i_core_ferr   (core_ferr),
    .m_if          (m_if),
    .o_fifo_level  (level),
    .o_overrun     (overrun),
    .o_ferr_sticky (ferr_sticky),
    .o_ferr_count  (ferr_count),
    .i_clr_status  (clr),
    .o_idle_to     (idle_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model, stepped on each rising edge from the inputs of the ending cycle.
  int         gap = 0, highs = 0, e_count = 0, e_to = 0;
  bit         e_tick = 0, e_sync = 1, e_run = 0, e_core_rst = 1;
  bit         e_overrun = 0, e_sticky = 0, e_prev_ferr = 0, e_idle_to = 0;
  bit         hist[$] = '{1'b1, 1'b1};
  logic [7:0] e_q[$];

  task automatic model_step();
    bit t, s, run, pop, pushed, rise;
    int sz;
    if (rst) begin
      gap = 0; highs = 0; e_count = 0; e_to = 0;
      e_tick = 0; e_sync = 1; e_run = 0; e_core_rst = 1;
      e_overrun = 0; e_sticky = 0; e_prev_ferr = 0; e_idle_to = 0;
      hist = '{1'b1, 1'b1};
      e_q.delete();
      return;
    end
    t = e_tick; s = e_sync; run = e_run; sz = e_q.size();
    // A tick follows every (baud+1) enabled cycles.
    if (!en) begin gap = 0; e_tick = 0; end
    else if (gap >= int'(baud)) begin gap = 0; e_tick = 1; end
    else begin gap++; e_tick = 0; end
    // The line appears two cycles late.
    hist.push_back(rx_pin);
    hist.delete(0);
    e_sync = hist[0];
    e_core_rst = !run;
    if (run) begin
      if (!en) e_run = 0;
    end else if (!en) highs = 0;
    else if (t) begin
      highs = s ? highs + 1 : 0;
      if (highs == 16) begin e_run = 1; highs = 0; end
    end
    pop = (sz != 0) && m_if.m_ready;
    pushed = 0;
    if (pop) e_q.delete(0);
    if (core_valid && run) begin
      if (sz < DEPTH || pop) begin e_q.push_back(core_data); pushed = 1; end
      else e_overrun = 1;
    end
    if (!(core_valid && run && !pushed) && clr) e_overrun = 0;
    rise = core_ferr && !e_prev_ferr;
    e_prev_ferr = core_ferr;
    if (rise) begin
      e_sticky = 1;
      e_count = clr ? 1 : (e_count < 255 ? e_count + 1 : 255);
    end else if (clr) begin
      e_sticky = 0; e_count = 0;
    end
    e_idle_to = 0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    if (pushed || sz == 0) e_to = 0;
    else if (t && e_to < TO_LIMIT) begin
      e_to++;
      if (e_to == TO_LIMIT) e_idle_to = 1;
    end
`endif
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("os_tick", 32'(os_tick), 32'(e_tick));
    chk("rx_sync", 32'(rx_sync), 32'(e_sync));
    chk("core_rst", 32'(core_rst), 32'(e_core_rst));
    chk("m_valid", 32'(m_if.m_valid), 32'(e_q.size() != 0));
    chk("fifo_level", 32'(level), 32'(e_q.size()));
    if (e_q.size() != 0) chk("m_data", 32'(m_if.m_data), 32'(e_q[0]));
    chk("overrun", 32'(overrun), 32'(e_overrun));
    chk("ferr_sticky", 32'(ferr_sticky), 32'(e_sticky));
    chk("ferr_count", 32'(ferr_count), 32'(e_count));
    chk("idle_to", 32'(idle_to), 32'(e_idle_to));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    core_data = b; core_valid = 1'b1;
    step(1);
    core_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g, pulses;
    bit seen;
    rst = 1; en = 0; baud = 16'd3; rx_pin = 0; core_valid = 0; core_data = '0;
    core_ferr = 0; clr = 0; m_if.m_ready = 0;
    step(2);
    chk("rst_os_tick", 32'(os_tick), 32'd0);
    chk("rst_rx_sync", 32'(rx_sync), 32'd1);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_m_valid", 32'(m_if.m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_m_data", 32'(m_if.m_data), 32'd0);
    chk("rst_ferr_count", 32'(ferr_count), 32'd0);
    rst = 0;
    step(1);

    // Tick period with baud_div=3, then restart after disable.
    en = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin step(1); seen = os_tick; end
    chk("first_tick_seen", 32'(seen), 32'd1);
    g = 0; seen = 0;
    while (!seen && g < 20) begin step(1); g++; seen = os_tick; end
    chk("tick_period", 32'(g), 32'd4);
    en = 0;
    step(1);
    chk("tick_off_when_disabled", 32'(os_tick), 32'd0);
    step(3);
    en = 1;
    g = 0; seen = 0;
    while (!seen && g < 20) begin step(1); g++; seen = os_tick; end
    chk("tick_restart_latency", 32'(g), 32'd4);

    // Idle hunt: low line, high run broken by a glitch, then a full idle run.
    step(40);
    chk("hunt_low_line", 32'(core_rst), 32'd1);
    rx_pin = 1; step(40);
    rx_pin = 0; step(8);
    rx_pin = 1; step(56);
    chk("hunt_after_glitch", 32'(core_rst), 32'd1);
    g = 0;
    while (core_rst && g < 100) begin step(1); g++; end
    chk("core_rst_released", 32'(core_rst), 32'd0);

    // Two bytes streamed straight through.
    m_if.m_ready = 1;
    core_data = 8'hA5; core_valid = 1; step(1);
    chk("stream_a5_valid", 32'(m_if.m_valid), 32'd1);
    chk("stream_a5_data", 32'(m_if.m_data), 32'hA5);
    core_data = 8'h3C; step(1);
    core_valid = 0;
    chk("stream_3c_data", 32'(m_if.m_data), 32'h3C);
    step(1);
    chk("stream_empty", 32'(m_if.m_valid), 32'd0);

    // Overflow: nine bytes into eight entries.
    m_if.m_ready = 0;
    for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
    chk("full_level", 32'(level), 32'd8);
    chk("full_overrun", 32'(overrun), 32'd1);
    m_if.m_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 32'(m_if.m_data), 32'h10 + 32'(i));
      step(1);
    end
    chk("drained_empty", 32'(m_if.m_valid), 32'd0);
    m_if.m_ready = 0;
    clr = 1; step(1); clr = 0;
    chk("overrun_cleared", 32'(overrun), 32'd0);
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    m_if.m_ready = 1;
    push_byte(8'h28);
    chk("full_push_pop_no_overrun", 32'(overrun), 32'd0);
    chk("full_push_pop_level", 32'(level), 32'd8);
    chk("full_push_pop_head", 32'(m_if.m_data), 32'h21);
    g = 0;
    while (level != 0 && g < 20) begin step(1); g++; end
    chk("refill_drained", 32'(level), 32'd0);
    m_if.m_ready = 0;

    // Framing errors: two edges, then clear racing a third edge.
    core_ferr = 1; step(2); core_ferr = 0; step(2);
    core_ferr = 1; step(2); core_ferr = 0; step(2);
    chk("ferr_count_two", 32'(ferr_count), 32'd2);
    chk("ferr_sticky_set", 32'(ferr_sticky), 32'd1);
    core_ferr = 1; clr = 1; step(1); clr = 0;
    chk("ferr_clr_race_count", 32'(ferr_count), 32'd1);
    chk("ferr_clr_race_sticky", 32'(ferr_sticky), 32'd1);
    core_ferr = 0; step(2);
    clr = 1; step(1); clr = 0;
    chk("ferr_cleared", 32'(ferr_count), 32'd0);

    // Idle timeout: one byte held with a tick every cycle.
    baud = 16'd0;
    step(2);
    push_byte(8'h77);
    pulses = 0;
    for (int i = 0; i < 700; i++) begin step(1); if (idle_to) pulses++; end
`ifdef UART_RX_CTRL_TIMEOUT_EN
    chk("idle_to_pulses", 32'(pulses), 32'd1);
`else
    chk("idle_to_pulses", 32'(pulses), 32'd0);
`endif
    chk("idle_byte_held", 32'(m_if.m_data), 32'h77);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
